// File: rtl/wash_pkg.sv
// Shared widths and default level thresholds for the wash timer/sensor unit.
package wash_pkg;

  localparam int unsigned LEVEL_W = 8;
  localparam int unsigned CNT_W   = 16;

  localparam logic [LEVEL_W-1:0] DEF_FULL_LEVEL  = 8'd200;
  localparam logic [LEVEL_W-1:0] DEF_EMPTY_LEVEL = 8'd10;

endpackage

// File: rtl/wash_debounce.sv
// Single-bit debouncer: output follows input after DEBOUNCE consecutive disagreeing cycles.
module wash_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       out_d;

  // Any cycle where input agrees with output restarts the run.
  always_comb begin
    cnt_d = '0;
    out_d = dout;
    if (din != dout) begin
      if (cnt_q == LAST) begin
        out_d = din;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      dout  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dout  <= out_d;
    end
  end

endmodule

// File: rtl/wash_timer_sensor_unit.sv
// Washing-machine support block: tick prescaler, cycle/spin timers, fill watchdog,
// debounced level and detergent flags, sticky fault.
module wash_timer_sensor_unit
  import wash_pkg::*;
#(
  parameter int unsigned         TICK_DIV    = 1000,
  parameter int unsigned         CYCLE_TICKS = 600,
  parameter int unsigned         SPIN_TICKS  = 300,
  parameter int unsigned         FILL_LIMIT  = 900,
  parameter logic [LEVEL_W-1:0]  FULL_LEVEL  = DEF_FULL_LEVEL,
  parameter logic [LEVEL_W-1:0]  EMPTY_LEVEL = DEF_EMPTY_LEVEL,
  parameter int unsigned         DEBOUNCE    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               motor_on,
  input  logic               fill_value_on,
  input  logic               drain_value_on,
  input  logic [LEVEL_W-1:0] level_raw,
  input  logic               detergent_sw,
  output logic               filled,
  output logic               drained,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic               fault
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CYC_MAX    = CNT_W'(CYCLE_TICKS);
  localparam logic [CNT_W-1:0] SPIN_MAX   = CNT_W'(SPIN_TICKS);
  localparam logic [CNT_W-1:0] FILL_MAX   = CNT_W'(FILL_LIMIT);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] spin_q, spin_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             tick, spin_phase, fill_active, fault_d;

  wash_debounce #(.DEBOUNCE(DEBOUNCE)) u_filled (
    .clk   (clk),
    .reset (reset),
    .din   (level_raw >= FULL_LEVEL),
    .dout  (filled)
  );

  wash_debounce #(.DEBOUNCE(DEBOUNCE)) u_drained (
    .clk   (clk),
    .reset (reset),
    .din   (level_raw <= EMPTY_LEVEL),
    .dout  (drained)
  );

  wash_debounce #(.DEBOUNCE(DEBOUNCE)) u_detergent (
    .clk   (clk),
    .reset (reset),
    .din   (detergent_sw),
    .dout  (detergent_added)
  );

  // Enable low clears even on a tick cycle; timers saturate at their limit.
  always_comb begin
    tick        = (presc_q == PRESC_LAST);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    spin_phase  = drain_value_on & drained;
    fill_active = fill_value_on & ~filled;

    cyc_d = cyc_q;
    if (!motor_on) begin
      cyc_d = '0;
    end else if (tick && cyc_q != CYC_MAX) begin
      cyc_d = cyc_q + 1'b1;
    end

    spin_d = spin_q;
    if (!spin_phase) begin
      spin_d = '0;
    end else if (tick && spin_q != SPIN_MAX) begin
      spin_d = spin_q + 1'b1;
    end

    fill_d = fill_q;
    if (!fill_active) begin
      fill_d = '0;
    end else if (tick && fill_q != FILL_MAX) begin
      fill_d = fill_q + 1'b1;
    end

    fault_d = fault | (fill_active & (fill_d == FILL_MAX)) | (fill_value_on & drain_value_on);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      cyc_q         <= '0;
      spin_q        <= '0;
      fill_q        <= '0;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
      fault         <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      cyc_q         <= cyc_d;
      spin_q        <= spin_d;
      fill_q        <= fill_d;
      cycle_timeout <= (cyc_d == CYC_MAX);
      spin_timeout  <= (spin_d == SPIN_MAX);
      fault         <= fault_d;
    end
  end

endmodule

// File: tb/tb_wash_timer_sensor_unit.sv
// Scoreboard bench: reference model pushes expected outputs per clock, monitor compares.
module tb_wash_timer_sensor_unit;

  localparam int TICK_DIV    = 4;
  localparam int CYCLE_TICKS = 5;
  localparam int SPIN_TICKS  = 3;
  localparam int FILL_LIMIT  = 6;
  localparam int DEBOUNCE    = 4;
  localparam int FULL_LVL    = 200;
  localparam int EMPTY_LVL   = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       motor_on = 1'b0;
  logic       fill_value_on = 1'b0;
  logic       drain_value_on = 1'b0;
  logic [7:0] level_raw = 8'd0;
  logic       detergent_sw = 1'b0;
  logic       filled, drained, detergent_added, cycle_timeout, spin_timeout, fault;

  always #5 clk = ~clk;

  wash_timer_sensor_unit #(
    .TICK_DIV    (TICK_DIV),
    .CYCLE_TICKS (CYCLE_TICKS),
    .SPIN_TICKS  (SPIN_TICKS),
    .FILL_LIMIT  (FILL_LIMIT),
    .FULL_LEVEL  (8'd200),
    .EMPTY_LEVEL (8'd10),
    .DEBOUNCE    (DEBOUNCE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .motor_on        (motor_on),
    .fill_value_on   (fill_value_on),
    .drain_value_on  (drain_value_on),
    .level_raw       (level_raw),
    .detergent_sw    (detergent_sw),
    .filled          (filled),
    .drained         (drained),
    .detergent_added (detergent_added),
    .cycle_timeout   (cycle_timeout),
    .spin_timeout    (spin_timeout),
    .fault           (fault)
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  // Reference model: elapsed-time bookkeeping plus a sliding window of raw samples per flag.
  int m_n, m_cyc, m_spin, m_fw;
  bit m_fault;
  bit m_flag[3];
  bit m_hist[3][$];
  bit m_tick, m_spin_ph, m_fill_act;

  function automatic void m_reset();
    m_n = 0; m_cyc = 0; m_spin = 0; m_fw = 0; m_fault = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_flag[i] = 1'b0;
      m_hist[i].delete();
    end
  endfunction

  function automatic void m_deb(int idx, bit s);
    bit all_diff;
    m_hist[idx].push_back(s);
    if (m_hist[idx].size() > DEBOUNCE) void'(m_hist[idx].pop_front());
    if (m_hist[idx].size() == DEBOUNCE) begin
      all_diff = 1'b1;
      foreach (m_hist[idx][i]) if (m_hist[idx][i] == m_flag[idx]) all_diff = 1'b0;
      if (all_diff) m_flag[idx] = s;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reset();
      exp_q.delete();
      exp_q.push_back(6'b0);
    end else begin
      m_tick     = (m_n % TICK_DIV) == TICK_DIV - 1;
      m_n        = m_n + 1;
      m_spin_ph  = drain_value_on && m_flag[1];
      m_fill_act = fill_value_on && !m_flag[0];
      m_cyc  = !motor_on  ? 0 : (m_cyc + int'(m_tick) > CYCLE_TICKS ? CYCLE_TICKS
                                                                      : m_cyc + int'(m_tick));
      m_spin = !m_spin_ph ? 0 : (m_spin + int'(m_tick) > SPIN_TICKS ? SPIN_TICKS
                                                                      : m_spin + int'(m_tick));
      m_fw   = !m_fill_act ? 0 : (m_fw + int'(m_tick) > FILL_LIMIT ? FILL_LIMIT
                                                                     : m_fw + int'(m_tick));
      if (m_fill_act && m_fw == FILL_LIMIT) m_fault = 1'b1;
      if (fill_value_on && drain_value_on) m_fault = 1'b1;
      m_deb(0, int'(level_raw) >= FULL_LVL);
      m_deb(1, int'(level_raw) <= EMPTY_LVL);
      m_deb(2, detergent_sw);
      exp_q.push_back({m_flag[0], m_flag[1], m_flag[2], m_cyc == CYCLE_TICKS,
                       m_spin == SPIN_TICKS, m_fault});
    end
  end

  logic [5:0] mon_exp, mon_got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {filled, drained, detergent_added, cycle_timeout, spin_timeout, fault};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL outputs{fill,drain,det,cyc_to,spin_to,fault} t=%0t got %b expected %b",
                 $time, mon_got, mon_exp);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    // Level rises to full, then a 3-cycle glitch that must be ignored.
    step(2);
    level_raw = 8'd220; step(8);
    level_raw = 8'd0;   step(3);
    level_raw = 8'd220; step(6);
    level_raw = 8'd100; step(6);
    // Wash cycle timer and its release.
    motor_on = 1'b1; step(28);
    motor_on = 1'b0; step(4);
    // Drain to empty then spin.
    level_raw = 8'd5; drain_value_on = 1'b1; step(25);
    drain_value_on = 1'b0; step(4);
    // Fill watchdog expiry.
    level_raw = 8'd50; fill_value_on = 1'b1; step(30);
    fill_value_on = 1'b0; step(5);
    // Reset mid-cycle, then counting restarts from zero.
    do_reset(2);
    motor_on = 1'b1; step(14);
    do_reset(1);
    step(26);
    motor_on = 1'b0; step(3);
    // Conflicting valve commands for one cycle.
    fill_value_on = 1'b1; drain_value_on = 1'b1; step(1);
    fill_value_on = 1'b0; drain_value_on = 1'b0; step(4);
    detergent_sw = 1'b1; step(6);
    detergent_sw = 1'b0; step(2);
    detergent_sw = 1'b1; step(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      if ($urandom_range(0, 39) == 0) motor_on = ~motor_on;
      if ($urandom_range(0, 29) == 0) begin
        fill_value_on = ~fill_value_on;
        if (fill_value_on && $urandom_range(0, 9) != 0) drain_value_on = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) begin
        drain_value_on = ~drain_value_on;
        if (drain_value_on && $urandom_range(0, 9) != 0) fill_value_on = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) detergent_sw = ~detergent_sw;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       level_raw = 8'($urandom_range(0, 15));
          1:       level_raw = 8'($urandom_range(190, 255));
          default: level_raw = 8'($urandom_range(0, 255));
        endcase
      end
      step(1);
    end

    step(2);
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain leftover=%0d expected<=1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
